// File: rtl/down_counter_load_if.sv
// Purpose: control/status bundle between a timer user and down_counter_load.
// Latency: none, wires only.
// Backpressure: none, the timer accepts a control word every cycle.
//
// Signals:
//   data    load value, sampled when load=1
//   load    synchronous load of data into count and reload registers
//   enable  count enable
//   mode    0 = one-shot, 1 = periodic auto-reload
//   out     current count (registered)
//   zero    high whenever out == 0
//   tc      one-cycle terminal-count pulse
//   running high while the timer is armed and counting
interface down_counter_load_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data;
    logic             load;
    logic             enable;
    logic             mode;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             tc;
    logic             running;

    // master: the block that programs the timer and watches its status
    modport master (
        output data, load, enable, mode,
        input  out, zero, tc, running
    );

    // slave: the timer itself
    modport slave (
        input  data, load, enable, mode,
        output out, zero, tc, running
    );
endinterface

// File: rtl/down_counter_load.sv
// Purpose: loadable down-counter/timer, one-shot or periodic, with terminal-count pulse.
// Latency: load->out 1 cycle, enable->decrement 1 cycle, tc on the edge out becomes 0.
// Backpressure: none; load/enable are honoured every cycle.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    down_counter_load_if.slave (data/load/enable/mode in, out/zero/tc/running out)
//
// Build option: DOWN_COUNTER_AUTO_RELOAD_EN enables periodic auto-reload through
// the mode input. Without it, mode is ignored and the timer is always one-shot.
module down_counter_load #(
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    down_counter_load_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] reload_reg;
    logic             tc_q;
    logic             periodic;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    assign periodic = bus.mode;
    logic unused_ok;
    assign unused_ok = 1'b0;
`else
    // mode is ignored and reload_reg is write-only in the one-shot-only build
    assign periodic = 1'b0;
    logic unused_ok;
    assign unused_ok = ^{bus.mode, reload_reg};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= CNT_ZERO;
            reload_reg <= CNT_ZERO;
            tc_q       <= 1'b0;
        end else begin
            // tc is a single-cycle pulse; only the 1->0 step re-raises it
            tc_q <= 1'b0;
            if (bus.load) begin
                // load wins over enable: no decrement on the load edge
                count      <= bus.data;
                reload_reg <= bus.data;
                state      <= RUN;
            end else if (state == RUN && bus.enable) begin
                if (count > CNT_ONE) begin
                    count <= count - CNT_ONE;
                end else if (count == CNT_ONE) begin
                    count <= CNT_ZERO;
                    tc_q  <= 1'b1;
                end else begin
                    // terminal cycle: count already 0, never wraps to all-ones
                    if (periodic) begin
                        count <= reload_reg;
                    end else begin
                        state <= DONE;
                    end
                end
            end
        end
    end

    assign bus.out     = count;
    assign bus.zero    = (count == CNT_ZERO);
    assign bus.tc      = tc_q;
    assign bus.running = (state == RUN);

endmodule

// File: tb/tb_down_counter_load.sv
// Purpose: directed self-checking bench for down_counter_load with an expectation queue.
// Latency: each step drives inputs, then checks the registered outputs 1 ns after the next edge.
// Backpressure: none; every step is a fixed single cycle.
module tb_down_counter_load;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] out;
        logic         tc;
        logic         running;
        string        tag;
    } exp_t;

    logic clk;
    logic reset;
    down_counter_load_if #(.WIDTH(W)) bus ();

    down_counter_load #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   vectors;
    int   miscompares;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Check the current outputs against one expectation entry.
    task automatic compare(input exp_t e);
        check({e.tag, ".out"},     bus.out, e.out);
        check({e.tag, ".zero"},    {{(W-1){1'b0}}, bus.zero},    {{(W-1){1'b0}}, (e.out == '0)});
        check({e.tag, ".tc"},      {{(W-1){1'b0}}, bus.tc},      {{(W-1){1'b0}}, e.tc});
        check({e.tag, ".running"}, {{(W-1){1'b0}}, bus.running}, {{(W-1){1'b0}}, e.running});
    endtask

    // Drive one cycle of stimulus, queue what the next edge must produce,
    // then pop and compare after the edge.
    task automatic step(input logic ld, input logic [W-1:0] d, input logic en, input logic md,
                        input logic [W-1:0] e_out, input logic e_tc, input logic e_run,
                        input string tag);
        exp_t e;
        bus.load   = ld;
        bus.data   = d;
        bus.enable = en;
        bus.mode   = md;
        e.out = e_out; e.tc = e_tc; e.running = e_run; e.tag = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: observed empty queue expected entry", tag);
        end else begin
            compare(exp_q.pop_front());
        end
    endtask

    initial begin
        exp_t r;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        bus.load    = 1'b0;
        bus.data    = '0;
        bus.enable  = 1'b0;
        bus.mode    = 1'b0;

        // Reset state
        #12;
        r.out = 8'h00; r.tc = 1'b0; r.running = 1'b0; r.tag = "reset";
        compare(r);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-count
        step(1, 8'h23, 0, 0, 8'h23, 0, 1, "mid_load");
        step(0, 8'h00, 1, 0, 8'h22, 0, 1, "mid_dec1");
        step(0, 8'h00, 1, 0, 8'h21, 0, 1, "mid_dec2");
        step(0, 8'h00, 1, 0, 8'h20, 0, 1, "mid_dec3");
        step(0, 8'h00, 1, 0, 8'h1F, 0, 1, "mid_dec4");
        #2;
        reset = 1'b0;
        #1;
        r.out = 8'h00; r.tc = 1'b0; r.running = 1'b0; r.tag = "mid_reset";
        compare(r);
        #2;
        reset = 1'b1;
        for (int i = 0; i < 5; i++)
            step(0, 8'h00, 1, 0, 8'h00, 0, 0, "idle_en");

        // One-shot
        step(1, 8'h05, 0, 0, 8'h05, 0, 1, "os_load");
        step(0, 8'h00, 1, 0, 8'h04, 0, 1, "os_4");
        step(0, 8'h00, 1, 0, 8'h03, 0, 1, "os_3");
        step(0, 8'h00, 1, 0, 8'h02, 0, 1, "os_2");
        step(0, 8'h00, 1, 0, 8'h01, 0, 1, "os_1");
        step(0, 8'h00, 1, 0, 8'h00, 1, 1, "os_0_tc");
        for (int i = 0; i < 10; i++)
            step(0, 8'h00, 1, 0, 8'h00, 0, 0, "os_done");

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        // Periodic: period 4, one tc per period
        step(1, 8'h03, 0, 1, 8'h03, 0, 1, "per_load");
        step(0, 8'h00, 1, 1, 8'h02, 0, 1, "per_2a");
        step(0, 8'h00, 1, 1, 8'h01, 0, 1, "per_1a");
        step(0, 8'h00, 1, 1, 8'h00, 1, 1, "per_0a");
        step(0, 8'h00, 1, 1, 8'h03, 0, 1, "per_3b");
        step(0, 8'h00, 1, 1, 8'h02, 0, 1, "per_2b");
        step(0, 8'h00, 1, 1, 8'h01, 0, 1, "per_1b");
        step(0, 8'h00, 1, 1, 8'h00, 1, 1, "per_0b");
        step(0, 8'h00, 1, 1, 8'h03, 0, 1, "per_3c");
        // Periodic with reload 0: stays at 0, never pulses, stays armed
        step(1, 8'h00, 0, 1, 8'h00, 0, 1, "per0_load");
        for (int i = 0; i < 4; i++)
            step(0, 8'h00, 1, 1, 8'h00, 0, 1, "per0_hold");
`else
        // mode ignored: always one-shot
        step(1, 8'h02, 0, 1, 8'h02, 0, 1, "nomac_load");
        step(0, 8'h00, 1, 1, 8'h01, 0, 1, "nomac_1");
        step(0, 8'h00, 1, 1, 8'h00, 1, 1, "nomac_0_tc");
        step(0, 8'h00, 1, 1, 8'h00, 0, 0, "nomac_done");
        step(0, 8'h00, 1, 1, 8'h00, 0, 0, "nomac_hold");
`endif

        // Enable gating
        step(1, 8'h0A, 0, 0, 8'h0A, 0, 1, "gate_load");
        step(0, 8'h00, 1, 0, 8'h09, 0, 1, "gate_9");
        step(0, 8'h00, 1, 0, 8'h08, 0, 1, "gate_8");
        step(0, 8'h00, 1, 0, 8'h07, 0, 1, "gate_7");
        for (int i = 0; i < 5; i++)
            step(0, 8'h00, 0, 0, 8'h07, 0, 1, "gate_hold");
        step(0, 8'h00, 1, 0, 8'h06, 0, 1, "gate_6");

        // Simultaneous load + enable
        step(0, 8'h00, 1, 0, 8'h05, 0, 1, "sim_5");
        step(0, 8'h00, 1, 0, 8'h04, 0, 1, "sim_4");
        step(1, 8'hFF, 1, 0, 8'hFF, 0, 1, "sim_ld_ff");
        step(1, 8'h00, 0, 0, 8'h00, 0, 1, "sim_ld_0");
        step(0, 8'h00, 1, 0, 8'h00, 0, 0, "sim_0_done");
        step(1, 8'h02, 0, 0, 8'h02, 0, 1, "sim_ld_2");
        step(0, 8'h00, 1, 0, 8'h01, 0, 1, "sim_1");
        step(1, 8'h09, 1, 0, 8'h09, 0, 1, "sim_ld_9");
        step(0, 8'h00, 1, 0, 8'h08, 0, 1, "sim_8");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/down_counter_load.md
# down_counter_load

Loadable down-counter/timer that pairs with the up-counter-with-load block. It counts a loaded value toward zero and flags the terminal count. It either stops at zero (one-shot) or reloads and repeats (periodic), and is used as the interval/timeout generator alongside the up-counter in the same clock domain.

## Interface
- `WIDTH`, default 8: width of the count, data and reload registers.
- `clk`  input  1  rising-edge clock; the block's only clock.
- `reset`  input  1  asynchronous, active-low reset.
- `data`  input  WIDTH  load value, sampled when `load`=1.
- `load`  input  1  synchronous load of `data` into count and reload registers.
- `enable`  input  1  count enable.
- `mode`  input  1  0 = one-shot, 1 = periodic auto-reload; sampled every cycle.
- `out`  output  WIDTH  current count (registered).
- `zero`  output  1  high whenever `out`==0; decoded from the `out` register, no extra latency.
- `tc`  output  1  registered one-cycle terminal-count pulse.
- `running`  output  1  high while FSM is in RUN.

## Operation
- FSM states:
  - IDLE: after reset; counter not armed.
  - RUN: armed; counting.
  - DONE: one-shot finished; holds zero.
- Per-edge priority: reset > load > enable > hold.
- `load`=1, from any state:
  - `out`<=`data`, `reload_reg`<=`data`, next state RUN, `tc`<=0.
  - `enable` is ignored that cycle; there is no decrement on the load edge.
- IDLE or DONE without `load`: `out` holds, `tc`=0, and `enable` has no effect.
- RUN, `enable`=1, `out`>1: `out`<=`out`-1, `tc`<=0.
- RUN, `enable`=1, `out`==1: `out`<=0, `tc`<=1. The pulse coincides with the first cycle `out` reads 0.
- RUN, `enable`=1, `out`==0 (terminal):
  - `mode`=0: `out` stays 0, next state DONE, `tc`<=0.
  - `mode`=1: `out`<=`reload_reg`, stay in RUN, `tc`<=0.
- RUN, `enable`=0: `out` and state hold, `tc`<=0.
- Arithmetic: unsigned, modulo-free. `out` never wraps from 0 to all-ones.
- Load of `data`=0: `out`=0 and `zero`=1 with no `tc`. The next enabled cycle takes the terminal branch.
- Periodic period is `reload_reg`+1 enabled cycles, with exactly one `tc` per period. With `reload_reg`=0: `out` stays 0 and `tc` is never raised.

## Timing
- Reset asserted takes effect immediately, independent of `clk`:
  - `out`=0, `reload_reg`=0, `zero`=1, `tc`=0, `running`=0, state IDLE.
- Reset asserted mid-count aborts the count with the same values.
- First functional edge is the first rising `clk` after `reset` returns high.
- Latencies:
  - `load` to `out`: 1 cycle.
  - `enable` to decrement: 1 cycle.
  - `tc` rises on the same edge `out` becomes 0 and lasts exactly one cycle.
- `zero` and `running` follow the registered state with no added delay.

## Configuration
- Macro `DOWN_COUNTER_AUTO_RELOAD_EN`.
- Defined: `mode` behaves as above (one-shot or periodic).
- Undefined:
  - The `mode` port remains but is ignored; the block is always one-shot.
  - `reload_reg` is still written on load but never read back into `out`.

## Test plan
- Reset mid-count: load 0x23, enable 4 cycles, then pull `reset` low between edges.
  - `out`=0, `zero`=1, `tc`=0, `running`=0 immediately, with no clock edge.
  - After release, `enable`=1 for 5 cycles keeps `out`=0 (IDLE).
- One-shot: `mode`=0, load 5, then `enable`=1.
  - `out`=5,4,3,2,1,0 on successive edges.
  - `tc`=1 only in the cycle `out` first reads 0.
  - Then DONE: `out` stays 0 for 10 more cycles and `tc` stays 0.
- Periodic (macro defined): `mode`=1, load 3, `enable`=1.
  - `out`=3,2,1,0,3,2,1,0,3.
  - `tc` pulses in each first-zero cycle, every 4 cycles.
- Enable gating: load 10, `enable`=1 for 3 cycles, then 0 for 5 cycles, then 1.
  - `out`=7 held for 5 cycles, then 6.
  - `running`=1 throughout.
- Simultaneous events:
  - At `out`=4, assert `load`=1 and `enable`=1 with `data`=0xFF: next `out`=0xFF, no decrement, `tc`=0.
  - Then load 0: `out`=0, `zero`=1, `tc`=0. The next enabled cycle enters DONE (`running`=0).
  - With `out`=1, `load`=1 with `data`=9 and `enable`=1: `out`=9, `tc`=0.
- Macro undefined: `mode`=1, load 2, `enable`=1.
  - `out`=2,1,0,0,0; a single `tc`; `running` drops after the terminal cycle.
